// File: rtl/pipeline_sink_buffer.sv
// rtl/pipeline_sink_buffer.sv - Stall-to-pop sink FIFO terminating the valid/stall pipeline
// Optional feature macro: PIPELINE_SINK_STALL_CNT_EN (saturating stalled-valid cycle counter)
module pipeline_sink_buffer #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_input,
    input  logic [WIDTH-1:0]       data_input,
    output logic                   stall_output,
    output logic                   valid_output,
    output logic [WIDTH-1:0]       data_output,
    input  logic                   pop_input,
    output logic [$clog2(DEPTH):0] count_output
`ifdef PIPELINE_SINK_STALL_CNT_EN
    ,
    output logic [15:0]            stall_cycles_output
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_full;
    logic w_push;
    logic w_pop;

    // Stall depends on registered occupancy only, so a same-cycle pop cannot admit a push.
    assign w_full       = (r_count == CW'(DEPTH));
    assign stall_output = w_full;
    assign valid_output = (r_count != '0);
    assign w_push       = valid_input & ~w_full;
    assign w_pop        = pop_input & valid_output;
    assign data_output  = valid_output ? r_mem[r_rd_ptr] : '0;
    assign count_output = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_input;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef PIPELINE_SINK_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (valid_input && w_full && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cycles_output = r_stall_cnt;
`endif

endmodule
